sort_serializer: RTL and testbench
==================================

# sort_serializer

Downstream stage of the combinational 4-input sorter. Captures the four sorted bytes `ra`..`rd` on a `load` pulse and streams them out one per beat over a valid/ready handshake, marking the last beat. It also checks that the captured group really is ordered, raising a sticky error flag otherwise, and counts the groups it has emitted.

## Interface
- `W`, 8, data width of each element (matches sorter ports)
- `DESCEND`, 0, expected order: 0 = `ra<=rb<=rc<=rd`, 1 = `ra>=rb>=rc>=rd`
- `CNT_W`, 16, width of group counter

- `clk` in 1 — single clock, all logic rising-edge.
- `rst` in 1 — synchronous, active-high reset.
- `load` in 1 — capture request for `ra`..`rd`. Honoured only when `busy`=0.
- `ra`, `rb`, `rc`, `rd` in W each — sorter outputs.
- `busy` out 1 — high while a group is being streamed.
- `out_data` out W — current element.
- `out_valid` out 1 — `out_data` is valid.
- `out_ready` in 1 — consumer accepts the beat.
- `out_last` out 1 — high on the fourth element of the group, qualified by `out_valid`.
- `order_err` out 1 — sticky order-violation flag.
- `grp_cnt` out CNT_W — groups fully emitted, modulo 2^CNT_W.

## Operation
- States:
  - IDLE: `busy`=0, `out_valid`=0.
  - SEND: `busy`=1, `out_valid`=1.
- IDLE → SEND when `load`=1:
  - Register `ra`,`rb`,`rc`,`rd` into `q0`..`q3`.
  - Beat index `idx` := 0.
- In SEND:
  - `out_data` = `q[idx]` and `out_last` = (`idx`==3).
  - A beat transfers when `out_valid` and `out_ready` are both high.
  - If `idx`<3, a transfer does `idx`+1.
  - If `idx`==3, a transfer returns to IDLE and does `grp_cnt`+1, wrapping to 0 past all-ones.
- `load` while `busy`=1 is ignored: no recapture, no queueing. This includes the cycle of the final transfer; `busy` is still 1 there.
- `out_data`, `out_last` and `idx` hold stable while `out_valid`=1 and `out_ready`=0. `out_valid` never drops mid-group.
- Order check, done on the captured inputs in the `load` cycle, unsigned compare:
  - DESCEND=0: violation if any of `ra>rb`, `rb>rc`, `rc>rd`.
  - DESCEND=1: violation if any of `ra<rb`, `rb<rc`, `rc<rd`.
  - Equal adjacent values are legal.
  - A violation sets `order_err` on the next edge. Only `rst` clears it.
  - A group with a violation is still streamed unchanged.
- `rst` takes priority over everything, including mid-group. It aborts the stream with no further beats and no `out_last`, and the partial group is not counted.

## Timing
- Reset values:
  - `busy`=0, `out_valid`=0, `out_last`=0.
  - `out_data`=0, `order_err`=0, `grp_cnt`=0.
  - `q0`..`q3`=0, `idx`=0.
- Latency: `load` sampled at edge N. `out_valid`=1 with `q0` is visible after edge N, i.e. in cycle N+1.
- With `out_ready` tied high:
  - Beats occur in cycles N+1..N+4, with `out_last` in N+4.
  - `busy`=0 in N+5, and the next `load` is accepted at N+5.
  - Peak throughput is one group per 5 cycles.
- Each cycle of `out_ready`=0 in SEND adds exactly one cycle.
- `grp_cnt` increments on the edge closing the `out_last` transfer and is visible in the following cycle.
- `order_err` is visible the cycle after `load`, together with the first `out_valid`.
- All outputs are registered or decoded from registered state. There is no combinational path from `out_ready` to `out_valid`.

## Test plan
- Reset check: hold `rst` for 2 cycles, then release. All outputs stay at reset values, and `load`=0 keeps the block in IDLE indefinitely.
- Ascending group, `out_ready`=1: `load` with 3,17,17,200.
  - `out_data` is 3,17,17,200 on 4 consecutive cycles starting 1 cycle after `load`.
  - `out_last` is high on the 200 beat only.
  - `grp_cnt`=1 and `order_err`=0.
- Backpressure: same group, with `out_ready` low on cycles 2 and 3 of SEND. The stream is 3,17,17,17,17,200, held beats repeating.
  - The consumer sees exactly 4 transfers.
  - `busy` falls 7 cycles after `load`.
- `load` while busy: load 1,2,3,4, then pulse `load` with 9,9,9,9 during beat 2 and again on the `out_last` cycle.
  - Output is exactly 1,2,3,4.
  - A `load` in the first IDLE cycle is then accepted.
- Order violation: load 10,5,20,30 with DESCEND=0. The stream is emitted unchanged, `order_err`=1 from the next cycle, and it stays 1 through later valid groups until `rst`.
- Counter wrap and abort:
  - With CNT_W=2, stream 5 groups and check `grp_cnt` sequence 1,2,3,0,1.
  - Then assert `rst` at beat 2 of a group. `out_valid` drops the next cycle and `grp_cnt`=0.

Source files
------------

// File: rtl/sort_serializer.sv
// ----------------------------------------------------------------------------
// sort_serializer
//
// Downstream stage of the combinational 4-input sorter. On a load pulse taken
// while idle, the four sorted elements ra..rd are captured and then streamed
// one per beat over a valid/ready handshake, with out_last marking the fourth
// beat. The captured group is checked for the expected ordering; a violation
// raises a sticky order_err (cleared only by rst). grp_cnt counts groups whose
// final beat has been accepted, wrapping modulo 2^CNT_W.
//
// Parameters:
//   W        element width
//   DESCEND  0: expect ra<=rb<=rc<=rd, 1: expect ra>=rb>=rc>=rd
//   CNT_W    width of the group counter
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset, aborts any group in flight
//   load       capture request, honoured only while busy=0
//   ra..rd     sorter outputs to capture
//   busy       high while a group is being streamed
//   out_data   current element (0 while idle)
//   out_valid  out_data is valid
//   out_ready  consumer accepts the beat
//   out_last   fourth element of the group, qualified by out_valid
//   order_err  sticky order-violation flag
//   grp_cnt    number of fully emitted groups
// ----------------------------------------------------------------------------
module sort_serializer #(
    parameter int unsigned W       = 8,
    parameter int unsigned DESCEND = 0,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [W-1:0]     ra,
    input  logic [W-1:0]     rb,
    input  logic [W-1:0]     rc,
    input  logic [W-1:0]     rd,
    output logic             busy,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             order_err,
    output logic [CNT_W-1:0] grp_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t       state;
    state_t       state_nx;
    logic [1:0]   idx;
    logic [1:0]   idx_nx;
    logic [W-1:0] q [4];

    logic accept;      // load honoured this cycle
    logic xfer;        // beat handed to the consumer this cycle
    logic asc_viol;
    logic desc_viol;
    logic viol;

    // ------------------------------------------------------------------------
    // Order check on the live inputs; only consulted in the capture cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        asc_viol  = (ra > rb) || (rb > rc) || (rc > rd);
        desc_viol = (ra < rb) || (rb < rc) || (rc < rd);
        viol      = (DESCEND != 0) ? desc_viol : asc_viol;
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode. Every output is a function of registered
    // state only, so out_ready never reaches out_valid combinationally.
    // ------------------------------------------------------------------------
    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        accept    = 1'b0;
        xfer      = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;

        case (state)
            IDLE: begin
                if (load) begin
                    accept   = 1'b1;
                    state_nx = SEND;
                    idx_nx   = '0;
                end
            end
            SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = q[idx];
                out_last  = (idx == 2'd3);
                xfer      = out_ready;
                if (xfer) begin
                    if (idx == 2'd3) begin
                        state_nx = IDLE;
                    end else begin
                        idx_nx = idx + 2'd1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Capture registers, sticky error flag and group counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            q[0]      <= '0;
            q[1]      <= '0;
            q[2]      <= '0;
            q[3]      <= '0;
            order_err <= 1'b0;
            grp_cnt   <= '0;
        end else begin
            if (accept) begin
                q[0] <= ra;
                q[1] <= rb;
                q[2] <= rc;
                q[3] <= rd;
                if (viol) begin
                    order_err <= 1'b1;
                end
            end
            // Counted on the edge that closes the last beat's transfer.
            if (xfer && out_last) begin
                grp_cnt <= grp_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sort_serializer.sv
// ----------------------------------------------------------------------------
// tb_sort_serializer
//
// Drives two instances from the same stimulus: dut_a (ascending, 2-bit group
// counter, scoreboarded beat by beat) and dut_d (descending, only its order
// check and a few beats are inspected). Expected beats are pushed when a group
// is loaded and popped by a monitor when dut_a transfers a beat.
// ----------------------------------------------------------------------------
module tb_sort_serializer;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic         out_ready;
    logic [W-1:0] ra, rb, rc, rd;

    logic         a_busy, a_out_valid, a_out_last, a_order_err;
    logic [W-1:0] a_out_data;
    logic [1:0]   a_grp_cnt;

    logic         d_busy, d_out_valid, d_out_last, d_order_err;
    logic [W-1:0] d_out_data;
    logic [15:0]  d_grp_cnt;

    sort_serializer #(.W(W), .DESCEND(0), .CNT_W(2)) dut_a (
        .clk(clk), .rst(rst), .load(load),
        .ra(ra), .rb(rb), .rc(rc), .rd(rd),
        .busy(a_busy), .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_last(a_out_last),
        .order_err(a_order_err), .grp_cnt(a_grp_cnt)
    );

    sort_serializer #(.W(W), .DESCEND(1), .CNT_W(16)) dut_d (
        .clk(clk), .rst(rst), .load(load),
        .ra(ra), .rb(rb), .rc(rc), .rd(rd),
        .busy(d_busy), .out_data(d_out_data), .out_valid(d_out_valid),
        .out_ready(out_ready), .out_last(d_out_last),
        .order_err(d_order_err), .grp_cnt(d_grp_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    beat_t      exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         xfers    = 0;
    logic [1:0] exp_cnt  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: a beat transfers on the next edge when valid and
    // ready are both high and rst is not asserted.
    always @(negedge clk) begin
        if (!rst && a_out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("beat_expected", exp_q.size(), 1);
            end else begin
                beat_t b;
                b = exp_q.pop_front();
                check("beat_data", a_out_data, b.data);
                check("beat_last", a_out_last, b.last);
                xfers++;
                if (b.last) exp_cnt = exp_cnt + 2'd1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a group with load=1 for one cycle; returns in cycle N+1.
    task automatic start_group(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] c, input logic [W-1:0] d);
        beat_t e;
        load = 1'b1;
        ra = a; rb = b; rc = c; rd = d;
        e.data = a; e.last = 1'b0; exp_q.push_back(e);
        e.data = b;                exp_q.push_back(e);
        e.data = c;                exp_q.push_back(e);
        e.data = d; e.last = 1'b1; exp_q.push_back(e);
        tick();
        load = 1'b0;
    endtask

    // Waits (bounded) for busy to fall; lat counts cycles since the load edge.
    task automatic wait_idle(input int start, output int lat);
        lat = start;
        while (a_busy && lat < 40) begin
            tick();
            lat++;
        end
        if (a_busy) check("idle_timeout", a_busy, 0);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        load = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        exp_cnt = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   lat;
        int   n0;
        int   exp_seq[5] = '{1, 2, 3, 0, 1};

        rst = 1'b1; load = 1'b0; out_ready = 1'b1;
        ra = '0; rb = '0; rc = '0; rd = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset values, and idle holds with load low
        for (int i = 0; i < 4; i++) begin
            check("rst_busy", a_busy, 0);
            check("rst_valid", a_out_valid, 0);
            tick();
        end
        check("rst_last", a_out_last, 0);
        check("rst_data", a_out_data, 0);
        check("rst_err", a_order_err, 0);
        check("rst_cnt", a_grp_cnt, 0);

        // Ascending group with out_ready high
        start_group(8'd3, 8'd17, 8'd17, 8'd200);
        check("asc_valid_n1", a_out_valid, 1);
        check("asc_data_n1", a_out_data, 3);
        check("asc_err", a_order_err, 0);
        check("desc_inst_err_on_asc", d_order_err, 1);
        tick(); tick(); tick();
        check("asc_last_n4", a_out_last, 1);
        check("asc_data_n4", a_out_data, 200);
        check("asc_cnt_n4", a_grp_cnt, 0);
        tick();
        check("asc_busy_n5", a_busy, 0);
        check("asc_valid_n5", a_out_valid, 0);
        check("asc_cnt_n5", a_grp_cnt, 1);
        check("asc_err_n5", a_order_err, 0);

        // Descending group: legal for dut_d, violation for dut_a
        do_reset();
        start_group(8'd200, 8'd17, 8'd17, 8'd3);
        check("desc_valid", d_out_valid, 1);
        check("desc_data", d_out_data, 200);
        check("desc_err", d_order_err, 0);
        check("asc_inst_err_on_desc", a_order_err, 1);
        tick(); tick(); tick();
        check("desc_last", d_out_last, 1);
        tick();
        check("desc_busy", d_busy, 0);
        check("desc_cnt", d_grp_cnt, 1);
        check("desc_err_after", d_order_err, 0);

        // Backpressure on cycles 2 and 3 of SEND
        do_reset();
        n0 = xfers;
        start_group(8'd3, 8'd17, 8'd17, 8'd200);
        tick();
        out_ready = 1'b0;
        tick();
        check("bp_held_data", a_out_data, 17);
        check("bp_held_last", a_out_last, 0);
        check("bp_held_valid", a_out_valid, 1);
        tick();
        out_ready = 1'b1;
        wait_idle(4, lat);
        check("bp_busy_fall", lat, 7);
        check("bp_xfers", xfers - n0, 4);
        check("bp_cnt", a_grp_cnt, 1);

        // load while busy is ignored, first idle cycle accepts
        n0 = xfers;
        start_group(8'd1, 8'd2, 8'd3, 8'd4);
        tick();
        load = 1'b1; ra = 8'd9; rb = 8'd9; rc = 8'd9; rd = 8'd9;
        tick();
        load = 1'b0;
        tick();
        check("lb_last", a_out_last, 1);
        load = 1'b1;
        tick();
        load = 1'b0;
        check("lb_idle", a_busy, 0);
        start_group(8'd5, 8'd6, 8'd7, 8'd8);
        check("lb_accept_valid", a_out_valid, 1);
        check("lb_accept_data", a_out_data, 5);
        wait_idle(1, lat);
        check("lb_xfers", xfers - n0, 8);
        check("lb_cnt", a_grp_cnt, exp_cnt);

        // Order violation, stream unchanged, flag sticky until rst
        start_group(8'd10, 8'd5, 8'd20, 8'd30);
        check("viol_err_next", a_order_err, 1);
        check("viol_valid", a_out_valid, 1);
        wait_idle(1, lat);
        start_group(8'd1, 8'd2, 8'd3, 8'd4);
        wait_idle(1, lat);
        check("viol_sticky", a_order_err, 1);
        do_reset();
        check("viol_cleared", a_order_err, 0);

        // Counter wrap with a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            start_group(8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3));
            wait_idle(1, lat);
            check("wrap_cnt", a_grp_cnt, exp_seq[i]);
        end

        // Reset during beat 2 aborts the group
        start_group(8'd50, 8'd60, 8'd70, 8'd80);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_valid", a_out_valid, 0);
        check("abort_busy", a_busy, 0);
        check("abort_last", a_out_last, 0);
        check("abort_cnt", a_grp_cnt, 0);
        check("abort_pending", exp_q.size(), 3);
        exp_q.delete();
        exp_cnt = '0;
        tick(); tick();
        check("abort_stays_idle", a_out_valid, 0);

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
